cmp_result_monitor: RTL and testbench



---
 rtl/cmp_pkg.sv | 27 ++
 rtl/sat_counter.sv | 28 ++
 rtl/cmp_result_monitor.sv | 145 ++++++++++++++
 tb/tb_cmp_result_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the comparator result monitor.
//   - one-hot comparator result codes
//   - ReadSel encodings (also the counter index order)
//   - read handshake FSM state type
//   - is_legal(): true for a one-hot result code
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  localparam logic [1:0] SEL_GT  = 2'd0;
  localparam logic [1:0] SEL_EQ  = 2'd1;
  localparam logic [1:0] SEL_LT  = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACK  = 2'd1,
    RD_REL  = 2'd2
  } rd_state_t;

  function automatic logic is_legal(input logic [2:0] r);
    return (r == CMP_GT) || (r == CMP_EQ) || (r == CMP_LT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   Clk   in  rising-edge clock
//   Reset in  asynchronous active-high reset
//   Clr   in  synchronous clear (wins over Inc)
//   Inc   in  increment enable
//   Q     out counter value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  logic [W-1:0] r_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                    r_q <= '0;
    else if (Clr)                 r_q <= '0;
    else if (Inc && (r_q != '1))  r_q <= r_q + 1'b1;
  end

  assign Q = r_q;

endmodule

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: classifies each accepted 3-bit comparator result as
// GT/EQ/LT/malformed, keeps saturating per-class counts, tracks runs of
// identical legal results, and serves counts to a host over a four-phase
// ReadReq/ReadAck handshake.
// Build option: define CMP_STREAK_ALARM_EN to build the streak tracker;
// without it StreakAlarm is tied low and no streak state exists.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   InValid, R          result strobe and one-hot result code {GT,EQ,LT}
//   ClearReq            synchronous clear of counters/streak/alarm/Error
//   ReadReq, ReadSel    host request level and counter select
//   ReadAck, ReadData   handshake acknowledge and counter snapshot
//   StreakAlarm         sticky long-run flag
//   Error               one-cycle pulse after a malformed result
module cmp_result_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [2:0]       R,
  input  logic             ClearReq,
  input  logic             ReadReq,
  input  logic [1:0]       ReadSel,
  output logic             ReadAck,
  output logic [CNT_W-1:0] ReadData,
  output logic             StreakAlarm,
  output logic             Error
);

  // A clear on the same edge discards the sample entirely.
  logic w_acc, w_legal;
  assign w_acc   = InValid & ~ClearReq;
  assign w_legal = is_legal(R);

  // Counter bank, indexed by the ReadSel encoding.
  logic [3:0]            w_inc;
  logic [3:0][CNT_W-1:0] w_cnt;

  always_comb begin
    w_inc          = '0;
    w_inc[SEL_GT]  = w_acc & (R == CMP_GT);
    w_inc[SEL_EQ]  = w_acc & (R == CMP_EQ);
    w_inc[SEL_LT]  = w_acc & (R == CMP_LT);
    w_inc[SEL_ERR] = w_acc & ~w_legal;
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Clr   (ClearReq),
      .Inc   (w_inc[g]),
      .Q     (w_cnt[g])
    );
  end

  logic r_error;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_error <= 1'b0;
    else       r_error <= w_acc & ~w_legal;
  end
  assign Error = r_error;

`ifdef CMP_STREAK_ALARM_EN
  localparam int LEN_W = $clog2(STREAK_TH + 1);
  localparam logic [LEN_W-1:0] LEN_TH = LEN_W'(STREAK_TH);

  logic [2:0]       r_last;
  logic             r_last_vld;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             r_alarm;

  always_comb begin
    w_len_nxt = r_len;
    if (w_acc) begin
      if (!w_legal)                         w_len_nxt = '0;
      else if (r_last_vld && (R == r_last)) w_len_nxt = (r_len == LEN_TH) ? r_len : r_len + 1'b1;
      else                                  w_len_nxt = LEN_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_len      <= '0;
      r_alarm    <= 1'b0;
    end else if (ClearReq) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_len      <= '0;
      r_alarm    <= 1'b0;
    end else if (w_acc) begin
      r_len      <= w_len_nxt;
      r_last     <= R;
      // A malformed code breaks the run: next legal result restarts at 1.
      r_last_vld <= w_legal;
      if (w_len_nxt == LEN_TH) r_alarm <= 1'b1;
    end
  end

  assign StreakAlarm = r_alarm;
`else
  assign StreakAlarm = 1'b0;
`endif

  // Read handshake FSM.
  rd_state_t r_state, w_state_nxt;
  logic      w_load;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= RD_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      RD_IDLE: if (ReadReq) begin
        w_state_nxt = RD_ACK;
        w_load      = 1'b1;
      end
      RD_ACK:  if (!ReadReq) w_state_nxt = RD_REL;
      RD_REL:  w_state_nxt = RD_IDLE;   // one dead cycle; ReadReq ignored
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Snapshot takes the counter value before this edge's increment/clear.
  logic [CNT_W-1:0] r_rdata;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       r_rdata <= '0;
    else if (w_load) r_rdata <= w_cnt[ReadSel];
  end

  assign ReadData = r_rdata;
  assign ReadAck  = (r_state == RD_ACK);

endmodule

// File: tb/tb_cmp_result_monitor.sv
module tb_cmp_result_monitor;
  import cmp_pkg::*;

  localparam int CNT_W     = 4;
  localparam int STREAK_TH = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;
`ifdef CMP_STREAK_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             InValid = 1'b0;
  logic [2:0]       R = 3'b000;
  logic             ClearReq = 1'b0;
  logic             ReadReq = 1'b0;
  logic [1:0]       ReadSel = 2'd0;
  logic             ReadAck;
  logic [CNT_W-1:0] ReadData;
  logic             StreakAlarm;
  logic             Error;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  cmp_result_monitor #(.CNT_W(CNT_W), .STREAK_TH(STREAK_TH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .R           (R),
    .ClearReq    (ClearReq),
    .ReadReq     (ReadReq),
    .ReadSel     (ReadSel),
    .ReadAck     (ReadAck),
    .ReadData    (ReadData),
    .StreakAlarm (StreakAlarm),
    .Error       (Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_cnt[4];
  bit               m_err;
  bit               m_alarm;
  int               m_phase;     // 0 idle, 1 acknowledging, 2 release cycle
  logic [CNT_W-1:0] m_rdata;
  logic [2:0]       m_hist[$];   // most recent accepted results since clear

  function automatic int cls(input logic [2:0] r);
    if (!$onehot(r)) return 3;
    if (r[2]) return 0;
    if (r[1]) return 1;
    return 2;
  endfunction

  // Alarm condition: the last STREAK_TH accepted results are all the same legal code.
  function automatic bit long_run();
    int n;
    n = m_hist.size();
    if (n < STREAK_TH) return 1'b0;
    for (int i = n - STREAK_TH; i < n; i++)
      if (!$onehot(m_hist[i]) || m_hist[i] != m_hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0; m_alarm = 1'b0; m_phase = 0; m_rdata = '0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: if (ReadReq) begin m_rdata = CNT_W'(m_cnt[ReadSel]); m_phase = 1; end
        1: if (!ReadReq) m_phase = 2;
        default: m_phase = 0;
      endcase
      m_err = 1'b0;
      if (ClearReq) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_alarm = 1'b0;
        m_hist.delete();
      end else if (InValid) begin
        int k;
        k = cls(R);
        if (m_cnt[k] < CMAX) m_cnt[k]++;
        m_err = (k == 3);
        m_hist.push_back(R);
        if (m_hist.size() > STREAK_TH) void'(m_hist.pop_front());
        if (ALARM_EN && long_run()) m_alarm = 1'b1;
      end
    end
  end

  always @(negedge Clk) begin
    if (started && !Reset) begin
      check("cmp_Error", {31'd0, Error}, {31'd0, m_err});
      check("cmp_StreakAlarm", {31'd0, StreakAlarm}, {31'd0, m_alarm});
      check("cmp_ReadAck", {31'd0, ReadAck}, {31'd0, (m_phase == 1)});
      check("cmp_ReadData", 32'(ReadData), 32'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic acc(input logic [2:0] r);
    InValid = 1'b1; R = r;
    tick();
    InValid = 1'b0;
  endtask

  task automatic clr();
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] sel, output logic [CNT_W-1:0] val);
    ReadSel = sel; ReadReq = 1'b1;
    tick();
    check("ack_latency", {31'd0, ReadAck}, 32'd1);
    val = ReadData;
    ReadReq = 1'b0;
    for (int i = 0; i < 8 && ReadAck; i++) tick();
    if (ReadAck) check("ack_release_timeout", {31'd0, ReadAck}, 32'd0);
    tick();
  endtask

  initial begin
    logic [CNT_W-1:0] v;
    #2 Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    started = 1'b1;
    tick();
    check("rst_ReadAck", {31'd0, ReadAck}, 32'd0);
    check("rst_ReadData", 32'(ReadData), 32'd0);
    check("rst_Error", {31'd0, Error}, 32'd0);
    check("rst_StreakAlarm", {31'd0, StreakAlarm}, 32'd0);
    do_read(SEL_EQ, v); check("rd_EQ_after_reset", 32'(v), 32'd0);

    // Basic classification
    acc(3'b100); acc(3'b010); acc(3'b001); acc(3'b010);
    do_read(SEL_GT, v);  check("rd_GT_1", 32'(v), 32'd1);
    do_read(SEL_EQ, v);  check("rd_EQ_2", 32'(v), 32'd2);
    do_read(SEL_LT, v);  check("rd_LT_1", 32'(v), 32'd1);
    do_read(SEL_ERR, v); check("rd_ERR_0", 32'(v), 32'd0);

    // Malformed codes
    acc(3'b000); check("err_pulse_000", {31'd0, Error}, 32'd1);
    acc(3'b011); check("err_pulse_011", {31'd0, Error}, 32'd1);
    tick();      check("err_drop", {31'd0, Error}, 32'd0);
    do_read(SEL_ERR, v); check("rd_ERR_2", 32'(v), 32'd2);
    do_read(SEL_GT, v);  check("rd_GT_still_1", 32'(v), 32'd1);
    do_read(SEL_EQ, v);  check("rd_EQ_still_2", 32'(v), 32'd2);

    // Streak alarm
    clr();
    acc(3'b010); acc(3'b010); acc(3'b010);
    check("streak_3_no_alarm", {31'd0, StreakAlarm}, 32'd0);
    acc(3'b010);
    check("streak_4_alarm", {31'd0, StreakAlarm}, {31'd0, ALARM_EN});
    tick();
    check("streak_sticky", {31'd0, StreakAlarm}, {31'd0, ALARM_EN});
    clr();
    check("streak_cleared", {31'd0, StreakAlarm}, 32'd0);
    acc(3'b010); acc(3'b010); acc(3'b000); acc(3'b010); acc(3'b010); acc(3'b010);
    check("streak_broken", {31'd0, StreakAlarm}, 32'd0);

    // Saturation
    clr();
    repeat (20) acc(3'b100);
    do_read(SEL_GT, v);  check("rd_GT_sat", 32'(v), 32'd15);
    do_read(SEL_ERR, v); check("rd_ERR_cleared", 32'(v), 32'd0);

    // Read + clear + sample on one edge, then handshake edges
    clr();
    repeat (5) acc(3'b100);
    ReadSel = SEL_GT; ReadReq = 1'b1; ClearReq = 1'b1; InValid = 1'b1; R = 3'b100;
    tick();
    ClearReq = 1'b0; InValid = 1'b0;
    check("combo_ack", {31'd0, ReadAck}, 32'd1);
    check("combo_data", 32'(ReadData), 32'd5);
    repeat (3) begin
      tick();
      check("ack_held", {31'd0, ReadAck}, 32'd1);
      check("data_held", 32'(ReadData), 32'd5);
    end
    ReadReq = 1'b0;
    tick(); check("ack_fall", {31'd0, ReadAck}, 32'd0);
    ReadReq = 1'b1;   // present only during the release cycle
    tick(); ReadReq = 1'b0;
    check("rel_ignore_a", {31'd0, ReadAck}, 32'd0);
    tick(); check("rel_ignore_b", {31'd0, ReadAck}, 32'd0);
    do_read(SEL_GT, v); check("rd_GT_discarded", 32'(v), 32'd0);

    // Reset during ACK
    ReadSel = SEL_LT; ReadReq = 1'b1;
    tick(); check("ack_before_reset", {31'd0, ReadAck}, 32'd1);
    #1 Reset = 1'b1;
    #1 check("reset_mid_ack", {31'd0, ReadAck}, 32'd0);
    ReadReq = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    check("post_reset_data", 32'(ReadData), 32'd0);
    check("post_reset_ack", {31'd0, ReadAck}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
